// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: round-robin sharing of the register-file write port,
// a one-cycle registered write stage and a per-register busy scoreboard.
module regfile_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NREQ   = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   rsv_valid,
  input  logic [ADDR_W-1:0]      rsv_addr,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
  output logic [2**ADDR_W-1:0]   busy
);

  localparam int PTR_W = $clog2(NREQ);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] cand;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] ptr_next;
  logic             gnt_any;

  // Rotating priority search starting at ptr; the write stage never stalls,
  // so a grant depends only on req_valid and the pointer.
  always_comb begin
    req_ready = '0;
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = PTR_W'((32'(ptr) + k) % NREQ);
      if (!gnt_any && !reset && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
    ptr_next = PTR_W'((32'(gnt_idx) + 32'd1) % NREQ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      busy     <= '0;
    end else begin
      rf_we <= gnt_any;
      if (gnt_any) begin
        ptr      <= ptr_next;
        rf_waddr <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
        rf_wdata <= req_data[gnt_idx*DATA_W +: DATA_W];
      end
      // Retire first, reserve second: a same-edge reservation of the retiring
      // register wins and leaves it busy.
      if (rf_we)     busy[rf_waddr] <= 1'b0;
      if (rsv_valid) busy[rsv_addr] <= 1'b1;
    end
  end

endmodule
